// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter slice.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bundle and FIFO write pins shared by the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = FIFO_DATA_W
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      full;
    logic                      wr_en;
    logic [DATA_W-1:0]         data_in;

    modport master (
        output req,
        output req_data,
        output full,
        input  gnt,
        input  wr_en,
        input  data_in
    );

    modport slave (
        input  req,
        input  req_data,
        input  full,
        output gnt,
        output wr_en,
        output data_in
    );

endinterface

// File: rtl/fifo_rr_picker.sv
// Rotating priority encoder: first asserted request at or above rr_ptr, with wrap.
module fifo_rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from farthest to nearest so the nearest candidate is written last.
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (req[IDX_W'(cand)]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; grant and write are same-cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fifo_wr_arbiter_if.slave           bus,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e       state_r, state_s;
    logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
    logic [IDX_W-1:0] owner_r, owner_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [IDX_W-1:0] gnt_idx_s, pick_idx_s;
    logic             gnt_vld_s, pick_vld_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    fifo_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (bus.req),
        .rr_ptr (rr_ptr_r),
        .valid  (pick_vld_s),
        .idx    (pick_idx_s)
    );

    // Arbitration state registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ARB_IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            cnt_r    <= '0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            owner_r  <= owner_s;
            cnt_r    <= cnt_s;
        end
    end

    // Next-state and grant decision; full blocks every grant.
    always_comb begin
        state_s   = state_r;
        rr_ptr_s  = rr_ptr_r;
        owner_s   = owner_r;
        cnt_s     = cnt_r;
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        case (state_r)
            ARB_IDLE: begin
                if (!bus.full && pick_vld_s) begin
                    gnt_vld_s = 1'b1;
                    gnt_idx_s = pick_idx_s;
                    if (BURST_LEN == 1) begin
                        rr_ptr_s = next_idx(pick_idx_s);
                    end else begin
                        state_s = ARB_BURST;
                        owner_s = pick_idx_s;
                        cnt_s   = CNT_W'(1);
                    end
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_BURST: begin
                if (bus.req[owner_r]) begin
                    if (!bus.full) begin
                        gnt_vld_s = 1'b1;
                        gnt_idx_s = owner_r;
                        cnt_s     = cnt_r + CNT_W'(1);
                        if (cnt_s == CNT_W'(BURST_LEN)) begin
                            state_s  = ARB_IDLE;
                            rr_ptr_s = next_idx(owner_r);
                            owner_s  = '0;
                            cnt_s    = '0;
                        end else begin
                            state_s = ARB_BURST;
                        end
                    end else begin
                        state_s = ARB_BURST;
                    end
                end else begin
                    // Owner released: one bubble cycle, then rotate past it.
                    state_s  = ARB_IDLE;
                    rr_ptr_s = next_idx(owner_r);
                    owner_s  = '0;
                    cnt_s    = '0;
                end
            end
            default: begin
                state_s  = ARB_IDLE;
                rr_ptr_s = '0;
                owner_s  = '0;
                cnt_s    = '0;
            end
        endcase
    end

    // FIFO write pins and grant vector, forced quiet while reset is held.
    always_comb begin
        bus.gnt     = '0;
        bus.wr_en   = 1'b0;
        bus.data_in = '0;
        if (rst && gnt_vld_s) begin
            bus.gnt   = {{(NUM_REQ - 1){1'b0}}, 1'b1} << gnt_idx_s;
            bus.wr_en = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_idx_s == IDX_W'(i)) begin
                    bus.data_in = bus.req_data[i*DATA_W +: DATA_W];
                end else begin
                    bus.data_in = bus.data_in;
                end
            end
        end else begin
            bus.wr_en = 1'b0;
        end
    end

    assign busy  = (state_r == ARB_BURST);
    assign owner = owner_r;

endmodule
